ro_measure_sequencer: RTL and testbench
=======================================

RO_MEASURE_SEQUENCER -- requirements
Module: ro_measure_sequencer

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 1000000, data_clk cycles per counting window (legal range 1..2^24-1).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4, idle cycles between window close and latch (legal range 1..255).
REQ-003 SHALL have parameter NUM_SEL, default 4, number of oscillator select settings per sweep (legal range 1..4).
REQ-004 SHALL have port data_clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port start  input  1  sweep request from RPi, level-sampled in IDLE only.
REQ-007 SHALL have port abort  input  1  synchronous abort of any sweep in progress.
REQ-008 SHALL have port tx_done  input  1  one-cycle pulse from the serializer marking the last frame bit.
REQ-009 SHALL have port C  output  2  oscillator select applied to the chip mux.
REQ-010 SHALL have port cnt_clear  output  1  one-cycle clear pulse to all RO counters.
REQ-011 SHALL have port cnt_enable  output  1  counting-window gate.
REQ-012 SHALL have port latch_en  output  1  one-cycle snapshot strobe for count registers.
REQ-013 SHALL have port tx_start  output  1  one-cycle serializer launch pulse.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse at sweep completion.
REQ-016 SHALL have port sweep_count  output  16  completed sweeps, saturating.

Function
REQ-017 SHALL implement FSM states IDLE, CLEAR, COUNT, SETTLE, LATCH, SEND, DONE; state register updates only on rising data_clk.
REQ-018 IDLE: start=1 SHALL move to CLEAR next cycle with C=0; start=0 SHALL hold IDLE.
REQ-019 CLEAR SHALL last exactly 1 cycle with cnt_clear=1, then enter COUNT.
REQ-020 COUNT SHALL hold cnt_enable=1 for exactly GATE_CYCLES consecutive cycles, then enter SETTLE.
REQ-021 SETTLE SHALL last exactly SETTLE_CYCLES cycles with cnt_enable=0, then enter LATCH.
REQ-022 LATCH SHALL last exactly 1 cycle with latch_en=1, then enter SEND.
REQ-023 SEND SHALL assert tx_start for exactly its first cycle, then wait indefinitely for tx_done.
REQ-024 tx_done in SEND (including same cycle as tx_start) SHALL leave SEND next cycle: to DONE if C==NUM_SEL-1, else to CLEAR with C incremented by 1.
REQ-025 DONE SHALL last 1 cycle with done=1, increment sweep_count unless at 16'hFFFF, reset C to 0, return to IDLE.
REQ-026 C SHALL change only on CLEAR entry and DONE, remaining stable through COUNT..SEND of each setting.
REQ-027 tx_done outside SEND and start outside IDLE SHALL be ignored.
REQ-028 abort=1 in any non-IDLE state SHALL force IDLE next cycle, C=0, all strobes/gate low, done not pulsed, sweep_count unchanged; abort has priority over tx_done and all other transitions.
REQ-029 All outputs SHALL be registered; strobes never exceed one cycle.

Reset
REQ-030 reset=0 SHALL, at the next rising edge, force IDLE, C=0, cnt_clear=0, cnt_enable=0, latch_en=0, tx_start=0, done=0, busy=0, sweep_count=0, internal counters=0.
REQ-031 reset SHALL take priority over abort, start and tx_done, including mid-sweep.

Structure
REQ-032 State encoding and the RO_SEL_WIDTH=2 constant SHALL reside in shared package ro_test_pkg.
REQ-033 Window/settle timing SHALL use one sub-module ro_window_timer (load, count-down, expire pulse), 24-bit.

Verification
REQ-034 GATE_CYCLES=8, SETTLE_CYCLES=2, NUM_SEL=4, start pulse, tx_done 5 cycles after each tx_start -> 4 cnt_clear, 32 total cnt_enable cycles, C sequence 0,1,2,3, one done pulse, sweep_count=1.
REQ-035 Abort in COUNT of C=2 -> IDLE next cycle, C=0, cnt_enable=0, no done, sweep_count unchanged.
REQ-036 tx_done coincident with tx_start -> SEND exits after 1 cycle; spurious tx_done during COUNT -> no state change.
REQ-037 reset=0 during SEND with C=1 -> all outputs at reset values next edge; subsequent start restarts at C=0.
REQ-038 Force sweep_count=16'hFFFE, run 3 sweeps -> saturates at 16'hFFFF.
REQ-039 start held high continuously, NUM_SEL=1 -> back-to-back sweeps, exactly 1 idle cycle between done and next cnt_clear.

Source files
------------

// File: rtl/ro_test_pkg.sv
// rtl/ro_test_pkg.sv - shared state encoding and widths for the RO measurement sequencer
package ro_test_pkg;

  localparam int RO_SEL_WIDTH = 2;
  localparam int TIMER_WIDTH  = 24;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_COUNT,
    S_SETTLE,
    S_LATCH,
    S_SEND,
    S_DONE
  } ro_state_t;

endpackage

// File: rtl/ro_window_timer.sv
// rtl/ro_window_timer.sv - loadable down-counter; expire marks the last enabled cycle of a window
module ro_window_timer
  import ro_test_pkg::*;
(
  input  logic                   data_clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [TIMER_WIDTH-1:0] load_value,
  input  logic                   enable,
  output logic                   expire
);

  logic [TIMER_WIDTH-1:0] remaining;

  always_ff @(posedge data_clk) begin
    if (!reset) begin
      remaining <= '0;
    end else if (load) begin
      remaining <= load_value;
    end else if (enable && (remaining != '0)) begin
      remaining <= remaining - TIMER_WIDTH'(1);
    end
  end

  assign expire = enable && (remaining == TIMER_WIDTH'(1));

endmodule

// File: rtl/ro_measure_sequencer.sv
// rtl/ro_measure_sequencer.sv - sweeps the RO select, gating/settling/latching counts and launching one frame per setting
module ro_measure_sequencer
  import ro_test_pkg::*;
#(
  parameter int GATE_CYCLES   = 1000000,
  parameter int SETTLE_CYCLES = 4,
  parameter int NUM_SEL       = 4
) (
  input  logic                    data_clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    tx_done,
  output logic [RO_SEL_WIDTH-1:0] C,
  output logic                    cnt_clear,
  output logic                    cnt_enable,
  output logic                    latch_en,
  output logic                    tx_start,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             sweep_count
);

  localparam logic [TIMER_WIDTH-1:0]  GATE_LOAD   = TIMER_WIDTH'(GATE_CYCLES);
  localparam logic [TIMER_WIDTH-1:0]  SETTLE_LOAD = TIMER_WIDTH'(SETTLE_CYCLES);
  localparam logic [RO_SEL_WIDTH-1:0] LAST_SEL    = RO_SEL_WIDTH'(NUM_SEL - 1);

  ro_state_t              state, next_state;
  logic                   timer_load, timer_en, timer_expire;
  logic [TIMER_WIDTH-1:0] timer_value;
  logic [15:0]            sweep_q;

  ro_window_timer u_timer (
    .data_clk   (data_clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .enable     (timer_en),
    .expire     (timer_expire)
  );

  always_comb begin
    next_state  = state;
    timer_load  = 1'b0;
    timer_en    = 1'b0;
    timer_value = GATE_LOAD;
    case (state)
      S_IDLE:   if (start) next_state = S_CLEAR;
      S_CLEAR: begin
        next_state = S_COUNT;
        timer_load = 1'b1;
      end
      S_COUNT: begin
        timer_en = 1'b1;
        if (timer_expire) begin
          next_state  = S_SETTLE;
          timer_load  = 1'b1;
          timer_value = SETTLE_LOAD;
        end
      end
      S_SETTLE: begin
        timer_en = 1'b1;
        if (timer_expire) next_state = S_LATCH;
      end
      S_LATCH:  next_state = S_SEND;
      S_SEND:   if (tx_done) next_state = (C == LAST_SEL) ? S_DONE : S_CLEAR;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) next_state = S_IDLE;
  end

  // Every output is registered from next_state so it lines up with the state it describes.
  always_ff @(posedge data_clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      C          <= '0;
      cnt_clear  <= 1'b0;
      cnt_enable <= 1'b0;
      latch_en   <= 1'b0;
      tx_start   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sweep_q    <= '0;
    end else begin
      state      <= next_state;
      cnt_clear  <= (next_state == S_CLEAR);
      cnt_enable <= (next_state == S_COUNT);
      latch_en   <= (next_state == S_LATCH);
      tx_start   <= (next_state == S_SEND) && (state != S_SEND);
      busy       <= (next_state != S_IDLE);
      done       <= (next_state == S_DONE);
      if ((next_state == S_IDLE) || (next_state == S_DONE)) begin
        C <= '0;
      end else if ((state == S_SEND) && (next_state == S_CLEAR)) begin
        C <= C + RO_SEL_WIDTH'(1);
      end
      if ((next_state == S_DONE) && (sweep_q != 16'hFFFF)) begin
        sweep_q <= sweep_q + 16'd1;
      end
    end
  end

  assign sweep_count = sweep_q;

endmodule

// File: tb/tb_ro_measure_sequencer.sv
// tb/tb_ro_measure_sequencer.sv - directed self-checking bench for ro_measure_sequencer
module tb_ro_measure_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0, start = 1'b0, abort = 1'b0, spur = 1'b0, resp_done = 1'b0;
  logic        tx_done;
  logic [1:0]  C;
  logic        cnt_clear, cnt_enable, latch_en, tx_start, busy, done;
  logic [15:0] sweep_count;

  logic        start1 = 1'b0;
  logic [1:0]  c1;
  logic        clr1, en1, lat1, txs1, busy1, done1;
  logic [15:0] sc1;

  int errors = 0, checks = 0;

  always #5 clk = ~clk;
  assign tx_done = resp_done | spur;

  ro_measure_sequencer #(.GATE_CYCLES(8), .SETTLE_CYCLES(2), .NUM_SEL(4)) dut (
    .data_clk(clk), .reset(reset), .start(start), .abort(abort), .tx_done(tx_done),
    .C(C), .cnt_clear(cnt_clear), .cnt_enable(cnt_enable), .latch_en(latch_en),
    .tx_start(tx_start), .busy(busy), .done(done), .sweep_count(sweep_count)
  );

  ro_measure_sequencer #(.GATE_CYCLES(3), .SETTLE_CYCLES(1), .NUM_SEL(1)) dut1 (
    .data_clk(clk), .reset(reset), .start(start1), .abort(1'b0), .tx_done(txs1),
    .C(c1), .cnt_clear(clr1), .cnt_enable(en1), .latch_en(lat1),
    .tx_start(txs1), .busy(busy1), .done(done1), .sweep_count(sc1)
  );

  // Serializer stand-in: answers each tx_start with tx_done resp_delay cycles later (0 = same cycle).
  logic resp_on = 1'b0;
  int   resp_delay = 5, pend = 0;
  always @(negedge clk) begin
    resp_done = 1'b0;
    if (!resp_on) pend = 0;
    else if (tx_start) begin
      if (resp_delay == 0) resp_done = 1'b1;
      else pend = resp_delay;
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) resp_done = 1'b1;
    end
  end

  int cyc = 0, n_clear = 0, n_en = 0, n_done = 0, run = 0, last_en_cyc = 0;
  int run_log[$], gap_log[$];
  logic [1:0] c_log[$];
  int n_done1 = 0, last_done1 = 0;
  bit seen_done1 = 0;
  int b2b_gap[$];
  logic b2b_busy[$];

  always @(negedge clk) begin
    cyc++;
    if (cnt_clear) begin n_clear++; c_log.push_back(C); end
    if (cnt_enable) begin n_en++; run++; last_en_cyc = cyc; end
    else if (run != 0) begin run_log.push_back(run); run = 0; end
    if (latch_en) gap_log.push_back(cyc - last_en_cyc - 1);
    if (done) n_done++;
    if (seen_done1 && cyc == last_done1 + 1) b2b_busy.push_back(busy1);
    if (clr1 && seen_done1) begin b2b_gap.push_back(cyc - last_done1); seen_done1 = 0; end
    if (done1) begin n_done1++; last_done1 = cyc; seen_done1 = 1; end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int base);
    for (int i = 0; i < 2000; i++) begin
      if (n_done != base) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (C !== 2'd0) begin errors++; $display("FAIL reset_c: got %0d want 0", C); end
    checks++; if ({cnt_clear, cnt_enable, latch_en, tx_start, done} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes: got %b want 00000", {cnt_clear, cnt_enable, latch_en, tx_start, done}); end
    checks++; if (sweep_count !== 16'd0) begin errors++; $display("FAIL reset_sweep_count: got %h want 0000", sweep_count); end
    checks++; if ({busy1, sc1} !== 17'd0) begin errors++; $display("FAIL reset_dut1: got %h want 0", {busy1, sc1}); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_hold: busy got %b want 0", busy); end
  endtask

  task automatic test_full_sweep();
    int b_clr, b_en, b_done, b_run, b_c, b_gap, rmin, rmax, gmin, gmax;
    logic [7:0] cseq;
    b_clr = n_clear; b_en = n_en; b_done = n_done; b_run = run_log.size(); b_c = c_log.size(); b_gap = gap_log.size();
    resp_delay = 5; resp_on = 1'b1;
    pulse_start();
    wait_done(b_done);
    checks++; if (n_done - b_done != 1) begin errors++; $display("FAIL full_done_pulses: got %0d want 1", n_done - b_done); end
    checks++; if (n_clear - b_clr != 4) begin errors++; $display("FAIL full_cnt_clear: got %0d want 4", n_clear - b_clr); end
    checks++; if (n_en - b_en != 32) begin errors++; $display("FAIL full_cnt_enable: got %0d want 32", n_en - b_en); end
    cseq = 8'hxx;
    if (c_log.size() >= b_c + 4) cseq = {c_log[b_c], c_log[b_c+1], c_log[b_c+2], c_log[b_c+3]};
    checks++; if (cseq !== 8'h1B) begin errors++; $display("FAIL full_c_sequence: got %h want 1b", cseq); end
    rmin = 999; rmax = 0;
    for (int i = b_run; i < run_log.size(); i++) begin
      if (run_log[i] < rmin) rmin = run_log[i];
      if (run_log[i] > rmax) rmax = run_log[i];
    end
    checks++; if (rmin != 8 || rmax != 8) begin errors++; $display("FAIL full_window_len: got %0d..%0d want 8..8", rmin, rmax); end
    gmin = 999; gmax = 0;
    for (int i = b_gap; i < gap_log.size(); i++) begin
      if (gap_log[i] < gmin) gmin = gap_log[i];
      if (gap_log[i] > gmax) gmax = gap_log[i];
    end
    checks++; if (gmin != 2 || gmax != 2) begin errors++; $display("FAIL full_settle_len: got %0d..%0d want 2..2", gmin, gmax); end
    checks++; if (sweep_count !== 16'd1) begin errors++; $display("FAIL full_sweep_count: got %h want 0001", sweep_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_idle_after: busy got %b want 0", busy); end
  endtask

  task automatic test_abort();
    int b_done;
    b_done = n_done;
    resp_delay = 5; resp_on = 1'b1;
    pulse_start();
    for (int i = 0; i < 1000; i++) begin
      if (C == 2'd2 && cnt_enable) break;
      @(negedge clk);
    end
    checks++; if (!(C === 2'd2 && cnt_enable === 1'b1)) begin errors++; $display("FAIL abort_reach_count: got C=%0d en=%b want C=2 en=1", C, cnt_enable); end
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++; if (C !== 2'd0) begin errors++; $display("FAIL abort_c: got %0d want 0", C); end
    checks++; if ({cnt_clear, cnt_enable, latch_en, tx_start, done} !== 5'b0) begin
      errors++; $display("FAIL abort_strobes: got %b want 00000", {cnt_clear, cnt_enable, latch_en, tx_start, done}); end
    repeat (20) @(negedge clk);
    checks++; if (n_done != b_done) begin errors++; $display("FAIL abort_no_done: got %0d want %0d", n_done, b_done); end
    checks++; if (sweep_count !== 16'd1) begin errors++; $display("FAIL abort_sweep_count: got %h want 0001", sweep_count); end
    resp_on = 1'b0;
  endtask

  task automatic test_tx_done_edges();
    int b_done, b_en;
    b_done = n_done; b_en = n_en;
    resp_delay = 0; resp_on = 1'b1;
    pulse_start();
    for (int i = 0; i < 100; i++) begin
      if (cnt_enable) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    spur = 1'b1;
    @(negedge clk) spur = 1'b0;
    checks++; if ({cnt_enable, busy, C} !== 4'b1100) begin errors++; $display("FAIL spurious_tx_done: got en,busy,C=%b want 1100", {cnt_enable, busy, C}); end
    for (int i = 0; i < 100; i++) begin
      if (tx_start) break;
      @(negedge clk);
    end
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL send_reached: got %b want 1", tx_start); end
    @(negedge clk);
    checks++; if ({cnt_clear, C} !== 3'b101) begin errors++; $display("FAIL send_exit_1cycle: got clr,C=%b want 101", {cnt_clear, C}); end
    wait_done(b_done);
    checks++; if (n_en - b_en != 32) begin errors++; $display("FAIL edge_cnt_enable: got %0d want 32", n_en - b_en); end
    checks++; if (sweep_count !== 16'd2) begin errors++; $display("FAIL edge_sweep_count: got %h want 0002", sweep_count); end
    resp_on = 1'b0;
  endtask

  task automatic test_reset_mid();
    int b_done;
    resp_delay = 5; resp_on = 1'b1;
    pulse_start();
    for (int i = 0; i < 1000; i++) begin
      if (C == 2'd1 && tx_start) break;
      @(negedge clk);
    end
    checks++; if (!(C === 2'd1 && tx_start === 1'b1)) begin errors++; $display("FAIL rst_reach_send: got C=%0d txs=%b want C=1 txs=1", C, tx_start); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if ({busy, C, cnt_clear, cnt_enable, latch_en, tx_start, done} !== 8'b0) begin
      errors++; $display("FAIL rst_mid_outputs: got %b want 00000000", {busy, C, cnt_clear, cnt_enable, latch_en, tx_start, done}); end
    checks++; if (sweep_count !== 16'd0) begin errors++; $display("FAIL rst_mid_sweep_count: got %h want 0000", sweep_count); end
    reset = 1'b1; resp_on = 1'b0;
    repeat (2) @(negedge clk);
    resp_on = 1'b1;
    b_done = n_done;
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      if (cnt_clear) break;
      @(negedge clk);
    end
    checks++; if ({cnt_clear, C} !== 3'b100) begin errors++; $display("FAIL rst_restart_c0: got clr,C=%b want 100", {cnt_clear, C}); end
    wait_done(b_done);
    checks++; if (sweep_count !== 16'd1) begin errors++; $display("FAIL rst_restart_count: got %h want 0001", sweep_count); end
  endtask

  task automatic test_saturate();
    logic [15:0] exp_count;
    int b_done;
    @(negedge clk) force dut.sweep_q = 16'hFFFE;
    @(negedge clk) release dut.sweep_q;
    @(negedge clk);
    checks++; if (sweep_count !== 16'hFFFE) begin errors++; $display("FAIL sat_preload: got %h want fffe", sweep_count); end
    exp_count = 16'hFFFE;
    resp_delay = 2; resp_on = 1'b1;
    for (int s = 0; s < 3; s++) begin
      b_done = n_done;
      pulse_start();
      wait_done(b_done);
      exp_count = (exp_count == 16'hFFFF) ? 16'hFFFF : exp_count + 16'd1;
      checks++; if (sweep_count !== exp_count) begin errors++; $display("FAIL sat_sweep%0d: got %h want %h", s, sweep_count, exp_count); end
    end
    resp_on = 1'b0;
  endtask

  task automatic test_back_to_back();
    int gmin, gmax, nbusy;
    start1 = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if (b2b_gap.size() >= 3) break;
      @(negedge clk);
    end
    start1 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy1) break;
    end
    checks++; if (b2b_gap.size() < 3) begin errors++; $display("FAIL b2b_restarts: got %0d want >=3", b2b_gap.size()); end
    gmin = 999; gmax = 0;
    foreach (b2b_gap[i]) begin
      if (b2b_gap[i] < gmin) gmin = b2b_gap[i];
      if (b2b_gap[i] > gmax) gmax = b2b_gap[i];
    end
    checks++; if (gmin != 2 || gmax != 2) begin errors++; $display("FAIL b2b_done_to_clear: got %0d..%0d want 2..2", gmin, gmax); end
    nbusy = 0;
    foreach (b2b_busy[i]) if (b2b_busy[i] !== 1'b0) nbusy++;
    checks++; if (nbusy != 0 || b2b_busy.size() == 0) begin errors++; $display("FAIL b2b_idle_cycle: got %0d busy of %0d want 0", nbusy, b2b_busy.size()); end
    checks++; if (int'(sc1) != n_done1 || n_done1 < 3) begin errors++; $display("FAIL b2b_sweep_count: got %0d want %0d (>=3)", sc1, n_done1); end
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_abort();
    test_tx_done_edges();
    test_reset_mid();
    test_saturate();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
